// File: rtl/led_pwm_driver_if.sv
// ----------------------------------------------------------------------------
// led_pwm_driver_if
// Duty-write and commit port of the LED PWM driver.
//
// Signals:
//   wr_valid    master->slave  duty write request
//   wr_ready    slave->master  write can be accepted (no commit pending)
//   wr_led      master->slave  target LED index
//   wr_chan     master->slave  0=blue, 1=green, 2=red, 3=all three
//   wr_duty     master->slave  duty value
//   commit_req  master->slave  single-cycle shadow->active request
//   commit_done slave->master  one-cycle pulse after the active bank loads
// ----------------------------------------------------------------------------
interface led_pwm_driver_if #(
    parameter int NUM_LEDS = 4,
    parameter int PWM_BITS = 8
);
    localparam int LED_W = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;

    logic                wr_valid;
    logic                wr_ready;
    logic [LED_W-1:0]    wr_led;
    logic [1:0]          wr_chan;
    logic [PWM_BITS-1:0] wr_duty;
    logic                commit_req;
    logic                commit_done;

    modport master (
        output wr_valid, wr_led, wr_chan, wr_duty, commit_req,
        input  wr_ready, commit_done
    );

    modport slave (
        input  wr_valid, wr_led, wr_chan, wr_duty, commit_req,
        output wr_ready, commit_done
    );
endinterface

// File: rtl/led_pwm_driver.sv
// ----------------------------------------------------------------------------
// led_pwm_driver
// Per-channel PWM driver for NUM_LEDS RGB LEDs. Duties are written into a
// shadow bank and copied to the active bank on a frame boundary after a
// commit request, so a colour change never tears mid-frame.
//
// Ports:
//   mainclk      system clock, all logic on posedge
//   rst_n        synchronous active-low reset
//   wr_bus       led_pwm_driver_if.slave: duty writes and commit handshake
//   frame_start  one-cycle pulse in the cycle after a frame boundary
//   led_b/g/r    registered PWM drive, bit i = LED i
// ----------------------------------------------------------------------------
module led_pwm_driver #(
    parameter int NUM_LEDS = 4,
    parameter int PWM_BITS = 8,
    parameter int PRESCALE = 1
) (
    input  logic                mainclk,
    input  logic                rst_n,
    led_pwm_driver_if.slave     wr_bus,
    output logic                frame_start,
    output logic [NUM_LEDS-1:0] led_b,
    output logic [NUM_LEDS-1:0] led_g,
    output logic [NUM_LEDS-1:0] led_r
);
    localparam int LED_W = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
    localparam int PS_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0] PS_MAX = PS_W'(PRESCALE - 1);

    typedef enum logic {IDLE, PENDING} commit_state_t;

    commit_state_t state, state_nxt;

    logic [PS_W-1:0]     prescaler;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic                tick;
    logic                boundary;
    logic                load_active;
    logic                wr_accept;

    logic [NUM_LEDS-1:0][PWM_BITS-1:0] shadow_b, shadow_g, shadow_r;
    logic [NUM_LEDS-1:0][PWM_BITS-1:0] active_b, active_g, active_r;

    assign tick             = (prescaler == PS_MAX);
    assign boundary         = tick && (pwm_cnt == {PWM_BITS{1'b1}});
    assign wr_bus.wr_ready  = (state != PENDING);
    assign wr_accept        = wr_bus.wr_valid && wr_bus.wr_ready;

    // Prescaler and PWM counter; the counter wraps naturally at 2**PWM_BITS
    always_ff @(posedge mainclk) begin
        if (!rst_n) begin
            prescaler <= '0;
            pwm_cnt   <= '0;
        end else if (tick) begin
            prescaler <= '0;
            pwm_cnt   <= pwm_cnt + PWM_BITS'(1);
        end else begin
            prescaler <= prescaler + PS_W'(1);
        end
    end

    always_ff @(posedge mainclk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A commit request arriving while already pending is dropped, not queued
    always_comb begin
        state_nxt   = state;
        load_active = 1'b0;
        case (state)
            IDLE: begin
                if (wr_bus.commit_req) begin
                    state_nxt = PENDING;
                end
            end
            PENDING: begin
                if (boundary) begin
                    load_active = 1'b1;
                    state_nxt   = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Out-of-range LED indices match no entry, so such writes are discarded
    always_ff @(posedge mainclk) begin
        if (!rst_n) begin
            shadow_b <= '0;
            shadow_g <= '0;
            shadow_r <= '0;
        end else if (wr_accept) begin
            for (int i = 0; i < NUM_LEDS; i++) begin
                if (wr_bus.wr_led == LED_W'(i)) begin
                    if (wr_bus.wr_chan == 2'd0 || wr_bus.wr_chan == 2'd3) begin
                        shadow_b[i] <= wr_bus.wr_duty;
                    end
                    if (wr_bus.wr_chan == 2'd1 || wr_bus.wr_chan == 2'd3) begin
                        shadow_g[i] <= wr_bus.wr_duty;
                    end
                    if (wr_bus.wr_chan == 2'd2 || wr_bus.wr_chan == 2'd3) begin
                        shadow_r[i] <= wr_bus.wr_duty;
                    end
                end
            end
        end
    end

    // Active bank load, PWM compare and status pulses. The compare uses the
    // pre-load active values, so a new duty shows up one cycle after the
    // counter has wrapped to 0.
    always_ff @(posedge mainclk) begin
        if (!rst_n) begin
            active_b           <= '0;
            active_g           <= '0;
            active_r           <= '0;
            led_b              <= '0;
            led_g              <= '0;
            led_r              <= '0;
            frame_start        <= 1'b0;
            wr_bus.commit_done <= 1'b0;
        end else begin
            frame_start        <= boundary;
            wr_bus.commit_done <= load_active;
            if (load_active) begin
                active_b <= shadow_b;
                active_g <= shadow_g;
                active_r <= shadow_r;
            end
            for (int i = 0; i < NUM_LEDS; i++) begin
                led_b[i] <= (pwm_cnt < active_b[i]);
                led_g[i] <= (pwm_cnt < active_g[i]);
                led_r[i] <= (pwm_cnt < active_r[i]);
            end
        end
    end
endmodule

// File: tb/tb_led_pwm_driver.sv
// ----------------------------------------------------------------------------
// tb_led_pwm_driver
// Drives two driver instances (PRESCALE=1 and PRESCALE=4) from the same
// stimulus. A reference model derives the PWM position from the number of
// cycles since reset release and tracks shadow/active duties and the commit
// request as plain arrays; every cycle the outputs are compared to it, and
// directed steps add explicit per-frame on-time counts.
// ----------------------------------------------------------------------------
module tb_led_pwm_driver;
    localparam int NL    = 4;
    localparam int PB    = 8;
    localparam int FRAME = 1 << PB;

    logic          mainclk    = 1'b0;
    logic          rst_n      = 1'b0;
    logic          wr_valid   = 1'b0;
    logic [1:0]    wr_led     = '0;
    logic [1:0]    wr_chan    = '0;
    logic [PB-1:0] wr_duty    = '0;
    logic          commit_req = 1'b0;

    logic          fs_a, fs_b;
    logic [NL-1:0] lb_a, lg_a, lr_a, lb_b, lg_b, lr_b;

    always #5 mainclk = ~mainclk;

    led_pwm_driver_if #(.NUM_LEDS(NL), .PWM_BITS(PB)) bus_a ();
    led_pwm_driver_if #(.NUM_LEDS(NL), .PWM_BITS(PB)) bus_b ();

    assign bus_a.wr_valid   = wr_valid;
    assign bus_a.wr_led     = wr_led;
    assign bus_a.wr_chan    = wr_chan;
    assign bus_a.wr_duty    = wr_duty;
    assign bus_a.commit_req = commit_req;
    assign bus_b.wr_valid   = wr_valid;
    assign bus_b.wr_led     = wr_led;
    assign bus_b.wr_chan    = wr_chan;
    assign bus_b.wr_duty    = wr_duty;
    assign bus_b.commit_req = commit_req;

    led_pwm_driver #(.NUM_LEDS(NL), .PWM_BITS(PB), .PRESCALE(1)) dut_a (
        .mainclk(mainclk), .rst_n(rst_n), .wr_bus(bus_a), .frame_start(fs_a),
        .led_b(lb_a), .led_g(lg_a), .led_r(lr_a)
    );

    led_pwm_driver #(.NUM_LEDS(NL), .PWM_BITS(PB), .PRESCALE(4)) dut_b (
        .mainclk(mainclk), .rst_n(rst_n), .wr_bus(bus_b), .frame_start(fs_b),
        .led_b(lb_b), .led_g(lg_b), .led_r(lr_b)
    );

    // Reference model state, index 0 = PRESCALE 1, index 1 = PRESCALE 4
    int            ps [2] = '{1, 4};
    int            n_cyc = 0;
    int            sh [2][NL][3];
    int            ac [2][NL][3];
    bit            pend [2];
    logic [NL-1:0] exp_led [2][3];
    logic          exp_fs [2];
    logic          exp_cd [2];

    int errors = 0;
    int checks = 0;
    int hi [2][3][NL];
    int cd_seen [2];

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Advances the model across one rising edge using the inputs seen there
    task automatic modelEdge(input logic r, input logic v, input logic [1:0] led,
                             input logic [1:0] chan, input logic [PB-1:0] duty, input logic creq);
        int pc;
        bit bnd;
        if (!r) begin
            n_cyc = 0;
            for (int d = 0; d < 2; d++) begin
                pend[d]   = 1'b0;
                exp_fs[d] = 1'b0;
                exp_cd[d] = 1'b0;
                for (int c = 0; c < 3; c++) begin
                    exp_led[d][c] = '0;
                    for (int i = 0; i < NL; i++) begin
                        sh[d][i][c] = 0;
                        ac[d][i][c] = 0;
                    end
                end
            end
        end else begin
            n_cyc++;
            for (int d = 0; d < 2; d++) begin
                pc  = ((n_cyc - 1) / ps[d]) % FRAME;
                bnd = (n_cyc % (FRAME * ps[d])) == 0;
                for (int c = 0; c < 3; c++) begin
                    for (int i = 0; i < NL; i++) begin
                        exp_led[d][c][i] = (pc < ac[d][i][c]);
                    end
                end
                exp_fs[d] = bnd;
                exp_cd[d] = pend[d] && bnd;
                if (v && !pend[d]) begin
                    for (int c = 0; c < 3; c++) begin
                        if (chan == 2'd3 || int'(chan) == c) begin
                            sh[d][led][c] = int'(duty);
                        end
                    end
                end
                if (pend[d] && bnd) begin
                    ac[d]   = sh[d];
                    pend[d] = 1'b0;
                end else if (!pend[d] && creq) begin
                    pend[d] = 1'b1;
                end
            end
        end
    endtask

    task automatic checkAll();
        checkOutput("a_led_b", 32'(lb_a), 32'(exp_led[0][0]));
        checkOutput("a_led_g", 32'(lg_a), 32'(exp_led[0][1]));
        checkOutput("a_led_r", 32'(lr_a), 32'(exp_led[0][2]));
        checkOutput("a_frame_start", 32'(fs_a), 32'(exp_fs[0]));
        checkOutput("a_commit_done", 32'(bus_a.commit_done), 32'(exp_cd[0]));
        checkOutput("a_wr_ready", 32'(bus_a.wr_ready), 32'(!pend[0]));
        checkOutput("b_led_b", 32'(lb_b), 32'(exp_led[1][0]));
        checkOutput("b_led_g", 32'(lg_b), 32'(exp_led[1][1]));
        checkOutput("b_led_r", 32'(lr_b), 32'(exp_led[1][2]));
        checkOutput("b_frame_start", 32'(fs_b), 32'(exp_fs[1]));
        checkOutput("b_commit_done", 32'(bus_b.commit_done), 32'(exp_cd[1]));
        checkOutput("b_wr_ready", 32'(bus_b.wr_ready), 32'(!pend[1]));
    endtask

    task automatic clearCounters();
        for (int d = 0; d < 2; d++) begin
            cd_seen[d] = 0;
            for (int c = 0; c < 3; c++) begin
                for (int i = 0; i < NL; i++) begin
                    hi[d][c][i] = 0;
                end
            end
        end
    endtask

    // One clock of stimulus: drive, clock, update model, compare, count
    task automatic applyStimulus(input logic r, input logic v, input logic [1:0] led,
                                 input logic [1:0] chan, input logic [PB-1:0] duty, input logic creq);
        rst_n      = r;
        wr_valid   = v;
        wr_led     = led;
        wr_chan    = chan;
        wr_duty    = duty;
        commit_req = creq;
        @(posedge mainclk);
        modelEdge(r, v, led, chan, duty, creq);
        #1;
        checkAll();
        for (int i = 0; i < NL; i++) begin
            hi[0][0][i] += int'(lb_a[i]);
            hi[0][1][i] += int'(lg_a[i]);
            hi[0][2][i] += int'(lr_a[i]);
            hi[1][0][i] += int'(lb_b[i]);
            hi[1][1][i] += int'(lg_b[i]);
            hi[1][2][i] += int'(lr_b[i]);
        end
        cd_seen[0] += int'(bus_a.commit_done);
        cd_seen[1] += int'(bus_b.commit_done);
    endtask

    task automatic idle(input int ncyc);
        for (int k = 0; k < ncyc; k++) applyStimulus(1'b1, 1'b0, 2'd0, 2'd0, '0, 1'b0);
    endtask

    task automatic waitDone(input int d, input int bound, input string tag);
        logic seen;
        int   k;
        seen = 1'b0;
        k    = 0;
        while (!seen && k < bound) begin
            idle(1);
            k++;
            seen = (d == 0) ? bus_a.commit_done : bus_b.commit_done;
        end
        checkOutput(tag, 32'(seen), 32'd1);
    endtask

    initial begin
        int first_fs;
        logic done_seen;

        $display("[TB] reset and idle frame timing");
        repeat (3) applyStimulus(1'b0, 1'b0, 2'd0, 2'd0, '0, 1'b0);
        checkOutput("reset_wr_ready", 32'(bus_a.wr_ready), 32'd1);
        checkOutput("reset_leds", 32'({lb_a, lg_a, lr_a}), 32'd0);
        first_fs = 0;
        for (int k = 1; k <= 300; k++) begin
            idle(1);
            if (fs_a && first_fs == 0) first_fs = k;
        end
        checkOutput("first_frame_start", 32'(first_fs), 32'd256);

        $display("[TB] led0 red = 128");
        applyStimulus(1'b1, 1'b1, 2'd0, 2'd2, 8'd128, 1'b0);
        applyStimulus(1'b1, 1'b0, 2'd0, 2'd0, '0, 1'b1);
        checkOutput("ready_low_pending", 32'(bus_a.wr_ready), 32'd0);
        waitDone(0, 600, "done_r0_seen");
        checkOutput("fs_with_done", 32'(fs_a), 32'd1);
        idle(1);
        clearCounters();
        idle(FRAME);
        checkOutput("r0_on_128", 32'(hi[0][2][0]), 32'd128);
        checkOutput("g0_on_0", 32'(hi[0][1][0]), 32'd0);

        $display("[TB] led1 green = 0, led2 blue = 255");
        applyStimulus(1'b1, 1'b1, 2'd1, 2'd1, 8'd0, 1'b0);
        applyStimulus(1'b1, 1'b1, 2'd2, 2'd0, 8'd255, 1'b1);
        waitDone(0, 600, "done_g1b2_seen");
        idle(1);
        clearCounters();
        idle(FRAME);
        checkOutput("g1_never_on", 32'(hi[0][1][1]), 32'd0);
        checkOutput("b2_on_255", 32'(hi[0][0][2]), 32'd255);

        $display("[TB] broadcast led3 = 64");
        applyStimulus(1'b1, 1'b1, 2'd3, 2'd3, 8'd64, 1'b1);
        waitDone(0, 600, "done_bcast_seen");
        idle(1);
        clearCounters();
        idle(FRAME);
        checkOutput("b3_on_64", 32'(hi[0][0][3]), 32'd64);
        checkOutput("g3_on_64", 32'(hi[0][1][3]), 32'd64);
        checkOutput("r3_on_64", 32'(hi[0][2][3]), 32'd64);

        $display("[TB] write held while pending, double commit");
        applyStimulus(1'b1, 1'b0, 2'd0, 2'd0, '0, 1'b1);
        clearCounters();
        done_seen = 1'b0;
        for (int k = 0; k < 600 && !done_seen; k++) begin
            applyStimulus(1'b1, 1'b1, 2'd0, 2'd0, 8'd200, k == 5);
            done_seen = bus_a.commit_done;
        end
        checkOutput("held_done_seen", 32'(done_seen), 32'd1);
        applyStimulus(1'b1, 1'b1, 2'd0, 2'd0, 8'd200, 1'b0);
        idle(300);
        checkOutput("single_commit_done", 32'(cd_seen[0]), 32'd1);
        checkOutput("b0_not_yet_active", 32'(hi[0][0][0]), 32'd0);
        applyStimulus(1'b1, 1'b0, 2'd0, 2'd0, '0, 1'b1);
        waitDone(0, 600, "done_b0_seen");
        idle(1);
        clearCounters();
        idle(FRAME);
        checkOutput("b0_on_200", 32'(hi[0][0][0]), 32'd200);

        $display("[TB] random traffic");
        for (int k = 0; k < 2500; k++) begin
            applyStimulus($urandom_range(0, 199) != 0, $urandom_range(0, 99) < 30,
                          2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                          PB'($urandom_range(0, 255)), $urandom_range(0, 99) < 3);
        end

        $display("[TB] prescale 4 timing");
        repeat (2) applyStimulus(1'b0, 1'b0, 2'd0, 2'd0, '0, 1'b0);
        applyStimulus(1'b1, 1'b1, 2'd1, 2'd2, 8'd32, 1'b1);
        waitDone(1, 2200, "done_p4_seen");
        idle(1);
        clearCounters();
        idle(4 * FRAME);
        checkOutput("p4_r1_on_128", 32'(hi[1][2][1]), 32'd128);

        $display("[TB] reset with commit pending");
        applyStimulus(1'b1, 1'b1, 2'd0, 2'd1, 8'd99, 1'b1);
        idle(100);
        checkOutput("p4_pending", 32'(bus_b.wr_ready), 32'd0);
        applyStimulus(1'b0, 1'b0, 2'd0, 2'd0, '0, 1'b0);
        checkOutput("p4_leds_after_reset", 32'({lb_b, lg_b, lr_b}), 32'd0);
        checkOutput("p4_ready_after_reset", 32'(bus_b.wr_ready), 32'd1);
        clearCounters();
        idle(1100);
        checkOutput("p4_dropped_commit", 32'(cd_seen[1]), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/led_pwm_driver.md
Name: led_pwm_driver

Overview:
- Per-channel PWM driver for the four Arty RGB LEDs (12 channels). It sits directly downstream of any LED pattern source.
- Upstream logic writes 8-bit duty values over a valid/ready port into a shadow bank. A commit request copies the shadow bank to the active bank at the next PWM frame boundary, so colours never tear mid-frame.
- Outputs drive the led*_b/g/r pins as packed buses.

Parameters:
- NUM_LEDS, 4, number of RGB LEDs (wr_led width = $clog2(NUM_LEDS), min 1).
- PWM_BITS, 8, duty and PWM counter width; frame = 2**PWM_BITS ticks.
- PRESCALE, 1, mainclk cycles per PWM tick (>=1).

Ports:
- mainclk  in  1  system clock; all logic on posedge.
- rst_n  in  1  synchronous active-low reset.
- wr_valid  in  1  duty write request.
- wr_ready  out  1  write can be accepted; equals ~commit_pending.
- wr_led  in  $clog2(NUM_LEDS)  target LED index.
- wr_chan  in  2  0=blue, 1=green, 2=red, 3=all three.
- wr_duty  in  PWM_BITS  duty value.
- commit_req  in  1  single-cycle request: shadow->active at next frame boundary.
- commit_done  out  1  one-cycle pulse in the cycle after the active bank is loaded.
- frame_start  out  1  one-cycle pulse in the cycle after a frame boundary.
- led_b  out  NUM_LEDS  blue drive, bit i = LED i.
- led_g  out  NUM_LEDS  green drive.
- led_r  out  NUM_LEDS  red drive.

Behaviour:
- Reset (rst_n=0 at posedge): prescaler, pwm_cnt, shadow and active banks, commit_pending all 0. Registered outputs led_*, commit_done and frame_start all 0. wr_ready reads 1 during reset, but writes and commits presented during reset are ignored.
- Prescaler: counts 0..PRESCALE-1. tick=1 when prescaler==PRESCALE-1, and the prescaler then wraps to 0. With PRESCALE=1, tick=1 every cycle.
- PWM counter: increments on tick, wraps from 2**PWM_BITS-1 to 0.
- Boundary: the cycle where tick && pwm_cnt==max. frame_start is registered and is 1 in the following cycle only.
- Output: led_x[i] <= (pwm_cnt < active_x[i]), compared as unsigned and registered. Each output therefore lags pwm_cnt by 1 cycle.
  - duty 0: always off.
  - duty 2**PWM_BITS-1: on for all but one tick per frame.
  - No full-on value exists.
- Write: accepted when wr_valid && wr_ready at posedge.
  - The accepted duty goes to shadow[wr_led][wr_chan].
  - wr_chan=3 writes the same duty to b, g and r of that LED.
  - wr_led >= NUM_LEDS: the write is accepted and discarded.
- Commit FSM, states IDLE and PENDING (commit_pending = state==PENDING):
  - IDLE + commit_req -> PENDING.
  - PENDING + boundary -> active <= shadow (all channels, same edge), then IDLE. commit_done=1 in the next cycle.
  - commit_req while PENDING is ignored and is not queued.
  - commit_req in IDLE on a boundary cycle still goes to PENDING; the copy happens at the following boundary.
  - An accepted write in the same cycle as commit_req (IDLE) is included in that commit.
- Active duties first affect outputs in the cycle after pwm_cnt returns to 0, i.e. 2 cycles after the boundary edge.
- Mid-operation reset: all state is cleared regardless of FSM state. A pending commit is dropped and outputs read 0 in the cycle after the reset edge.

Test Plan:
- Reset, PRESCALE=1: hold rst_n=0 for 3 cycles, then release -> all led_* = 0, wr_ready=1. frame_start pulses every 256 cycles, first pulse 256 cycles after release.
- Write led0 red=128, then commit -> wr_ready=0 until the boundary.
  - commit_done and frame_start pulse in the same cycle.
  - Thereafter led_r[0] is high exactly 128 consecutive cycles per 256-cycle frame; all other outputs stay 0.
- Write duty 0 to led1 green and 255 to led2 blue, then commit -> led_g[1] is never high. led_b[2] is low exactly 1 cycle per frame, the cycle after pwm_cnt==255.
- Broadcast: wr_led=3, wr_chan=3, duty=64, then commit -> led_b[3], led_g[3] and led_r[3] are identical, each high 64 cycles per frame.
- Handshake while PENDING: hold wr_valid=1 with duty=200 -> not accepted until wr_ready rises. A second commit_req during PENDING produces only one commit_done. The held write lands in shadow and takes effect only after a new commit.
- PRESCALE=4: frame = 1024 cycles; duty 32 -> high 128 cycles per frame. Assert rst_n=0 mid-frame with a commit pending -> outputs 0 in the next cycle, and commit_done never fires for the dropped commit.
